// File: rtl/sram_bytelane.sv
// sram_bytelane: word-organised byte-lane data SRAM with a valid/ready request
// port and a registered one-cycle response. Byte i of a request targets
// address req_addr+i (wrapping at the top of memory).
// Optional feature macro: SRAM_MISALIGN_EN. When defined, requests whose bytes
// cross a word boundary are split into two word accesses. When undefined they
// are answered with rsp_err=1 and leave memory untouched.
module sram_bytelane #(
    parameter int ADDR_W = 16,
    parameter int NB     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [NB-1:0]     req_strb,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [8*NB-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [8*NB-1:0]   rsp_rdata,
    output logic              rsp_err
);
    localparam int OFF_W  = $clog2(NB);
    localparam int POS_W  = OFF_W + 1;
    localparam int WORD_W = ADDR_W - OFF_W;
    localparam int DEPTH  = 1 << WORD_W;

`ifdef SRAM_MISALIGN_EN
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SECOND = 1'b1} state_t;
`else
    typedef enum logic [0:0] {ST_IDLE = 1'b0} state_t;
`endif

    // Storage: one word per entry, NB byte lanes each.
    logic [NB-1:0][7:0] mem_r [DEPTH];

    state_t              state_r;
    state_t              state_nx_s;
    logic                req_ready_r;
    logic                rsp_valid_r;
    logic [8*NB-1:0]     rsp_rdata_r;
    logic                rsp_err_r;

    logic                accept_s;
    logic                cross_s;
    logic                acc_phase_s;   // 0: first/only word, 1: following word
    logic [WORD_W-1:0]   acc_word_s;
    logic [OFF_W-1:0]    acc_off_s;
    logic [NB-1:0]       acc_strb_s;
    logic [8*NB-1:0]     acc_wdata_s;
    logic                acc_we_s;
    logic                acc_en_s;      // memory is accessed at this edge
    logic                done_s;        // a response is produced at this edge
    logic                err_s;
    logic [NB-1:0][7:0]  rd_word_s;
    logic [NB-1:0]       lane_we_s;
    logic [NB-1:0][7:0]  lane_wdata_s;
    logic [8*NB-1:0]     rd_bytes_s;    // read bytes in request byte order
    logic [8*NB-1:0]     first_half_s;
    logic [8*NB-1:0]     rsp_data_nx_s;

`ifdef SRAM_MISALIGN_EN
    logic [WORD_W-1:0]   hold_word_r;
    logic [OFF_W-1:0]    hold_off_r;
    logic [NB-1:0]       hold_strb_r;
    logic [8*NB-1:0]     hold_wdata_r;
    logic                hold_we_r;
    logic [8*NB-1:0]     hold_rdata_r;
`endif

    assign accept_s  = req_valid && req_ready_r;
    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

    // Detect a request whose selected bytes spill past the end of its word.
    always_comb begin
        cross_s = 1'b0;
        for (int i = 0; i < NB; i++) begin
            cross_s = cross_s | (req_strb[i] &&
                      ((POS_W'(req_addr[OFF_W-1:0]) + POS_W'(i)) >= POS_W'(NB)));
        end
    end

    // Next-state logic: only a split crossing request leaves IDLE.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
`ifdef SRAM_MISALIGN_EN
                if (accept_s && cross_s) begin
                    state_nx_s = ST_SECOND;
                end else begin
                    state_nx_s = ST_IDLE;
                end
`else
                state_nx_s = ST_IDLE;
`endif
            end
`ifdef SRAM_MISALIGN_EN
            ST_SECOND: state_nx_s = ST_IDLE;
`endif
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Select which request drives the word access this cycle.
    always_comb begin
        acc_phase_s = 1'b0;
        acc_word_s  = req_addr[ADDR_W-1:OFF_W];
        acc_off_s   = req_addr[OFF_W-1:0];
        acc_strb_s  = req_strb;
        acc_wdata_s = req_wdata;
        acc_we_s    = req_we;
        acc_en_s    = 1'b0;
        done_s      = 1'b0;
        err_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
`ifdef SRAM_MISALIGN_EN
                    acc_en_s = 1'b1;
                    done_s   = !cross_s;
`else
                    acc_en_s = !cross_s;
                    done_s   = 1'b1;
                    err_s    = cross_s;
`endif
                end else begin
                    acc_en_s = 1'b0;
                end
            end
`ifdef SRAM_MISALIGN_EN
            ST_SECOND: begin
                acc_phase_s = 1'b1;
                acc_word_s  = hold_word_r + WORD_W'(1);
                acc_off_s   = hold_off_r;
                acc_strb_s  = hold_strb_r;
                acc_wdata_s = hold_wdata_r;
                acc_we_s    = hold_we_r;
                acc_en_s    = 1'b1;
                done_s      = 1'b1;
            end
`endif
            default: begin
                acc_en_s = 1'b0;
                done_s   = 1'b0;
            end
        endcase
    end

    // Map request bytes onto word lanes for the current access phase.
    always_comb begin
        logic [OFF_W:0] pos_v;
        pos_v        = '0;
        lane_we_s    = '0;
        lane_wdata_s = '0;
        rd_bytes_s   = '0;
        rd_word_s    = mem_r[acc_word_s];
        for (int i = 0; i < NB; i++) begin
            pos_v = POS_W'(acc_off_s) + POS_W'(i);
            if (acc_strb_s[i] && (pos_v[OFF_W] == acc_phase_s)) begin
                lane_we_s[pos_v[OFF_W-1:0]]    = acc_we_s;
                lane_wdata_s[pos_v[OFF_W-1:0]] = acc_wdata_s[8*i +: 8];
                rd_bytes_s[8*i +: 8]           = rd_word_s[pos_v[OFF_W-1:0]];
            end else begin
                rd_bytes_s[8*i +: 8] = 8'h00;
            end
        end
    end

    // Assemble response data; writes and rejected requests return zero.
    always_comb begin
`ifdef SRAM_MISALIGN_EN
        first_half_s = acc_phase_s ? hold_rdata_r : '0;
`else
        first_half_s = '0;
`endif
        if (acc_we_s || err_s) begin
            rsp_data_nx_s = '0;
        end else begin
            rsp_data_nx_s = rd_bytes_s | first_half_s;
        end
    end

    // Per-lane memory write; contents are intentionally never reset.
    always_ff @(posedge clk) begin
        for (int l = 0; l < NB; l++) begin
            if (acc_en_s && !rst && lane_we_s[l]) begin
                mem_r[acc_word_s][l] <= lane_wdata_s[l];
            end
        end
    end

    // State register and registered ready (low during reset).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            req_ready_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            req_ready_r <= (state_nx_s == ST_IDLE);
        end
    end

`ifdef SRAM_MISALIGN_EN
    // Hold a crossing request and its first-half read bytes for the second access.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_word_r  <= '0;
            hold_off_r   <= '0;
            hold_strb_r  <= '0;
            hold_wdata_r <= '0;
            hold_we_r    <= 1'b0;
            hold_rdata_r <= '0;
        end else if ((state_r == ST_IDLE) && accept_s) begin
            hold_word_r  <= acc_word_s;
            hold_off_r   <= acc_off_s;
            hold_strb_r  <= acc_strb_s;
            hold_wdata_r <= acc_wdata_s;
            hold_we_r    <= acc_we_s;
            hold_rdata_r <= rd_bytes_s;
        end
    end
`endif

    // Response registers: one-cycle valid pulse, data/err held until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= '0;
            rsp_err_r   <= 1'b0;
        end else begin
            rsp_valid_r <= done_s;
            if (done_s) begin
                rsp_rdata_r <= rsp_data_nx_s;
                rsp_err_r   <= err_s;
            end
        end
    end
endmodule
